demux3_lane_dispatcher: RTL and testbench

Sequential 1-to-3 dispatcher. It is the producing end of a three-way AND-OR merge: it fans one valid/ready word stream out to three lanes, and the three lanes feed an AO222-style combine stage. Each incoming word is steered to a lane by an explicit destination code or by a round-robin pointer. Each lane has a one-entry output register and an accepted-word counter, which the power-characterisation benches use to produce controlled per-lane switching activity.

---
 rtl/demux3_pkg.sv | 28 ++
 rtl/demux3_lane_dispatcher_lane_slot.sv | 44 ++++
 rtl/demux3_lane_dispatcher.sv | 84 ++++++++
 tb/tb_demux3_lane_dispatcher.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux3_pkg.sv
// Shared constants and types for the three-lane word dispatcher.
// Destination codes, lane count and the round-robin pointer type.
package demux3_pkg;

   localparam int NUM_LANES = 3;

   localparam logic [1:0] DEST_L0 = 2'd0;
   localparam logic [1:0] DEST_L1 = 2'd1;
   localparam logic [1:0] DEST_L2 = 2'd2;
   localparam logic [1:0] DEST_RR = 2'd3;

   typedef enum logic [1:0] {
      RR_L0 = 2'd0,
      RR_L1 = 2'd1,
      RR_L2 = 2'd2
   } rr_t;

   function automatic rr_t rr_next(input rr_t cur);
      rr_t nxt;
      unique case (cur)
         RR_L0:   nxt = RR_L1;
         RR_L1:   nxt = RR_L2;
         default: nxt = RR_L0;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/demux3_lane_dispatcher_lane_slot.sv
// One output lane: single-entry word register with valid flag
// and a free-running count of words loaded into the lane.
module lane_slot
   import demux3_pkg::*;
#(
   parameter int DW = 8,
   parameter int CW = 8
) (
   input  logic          CLK,
   input  logic          RSTB,
   input  logic          load,
   input  logic [DW-1:0] data_in,
   input  logic          ready_in,
   output logic          valid_out,
   output logic [DW-1:0] data_out,
   output logic [CW-1:0] cnt,
   output logic          free
);

   logic          valid_q;
   logic [DW-1:0] data_q;
   logic [CW-1:0] cnt_q;

   // A full lane that drains this cycle can take a new word at once.
   assign free      = ~valid_q | ready_in;
   assign valid_out = valid_q;
   assign data_out  = data_q;
   assign cnt       = cnt_q;

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else if (load) begin
         valid_q <= 1'b1;
         data_q  <= data_in;
         cnt_q   <= cnt_q + 1'b1;
      end else if (valid_q && ready_in) begin
         valid_q <= 1'b0;
      end
   end

endmodule

// File: rtl/demux3_lane_dispatcher.sv
// 1-to-3 valid/ready dispatcher: explicit or round-robin lane select,
// one registered entry per lane, in-order with head-of-line blocking.
module demux3_lane_dispatcher
   import demux3_pkg::*;
#(
   parameter int DW = 8,
   parameter int CW = 8
) (
   input  logic          CLK,
   input  logic          RSTB,
   input  logic [DW-1:0] IN_DATA,
   input  logic [1:0]    IN_DEST,
   input  logic          IN_VALID,
   output logic          IN_READY,
   output logic [DW-1:0] OUT_DATA0,
   output logic [DW-1:0] OUT_DATA1,
   output logic [DW-1:0] OUT_DATA2,
   output logic [2:0]    OUT_VALID,
   input  logic [2:0]    OUT_READY,
   output logic [CW-1:0] CNT0,
   output logic [CW-1:0] CNT1,
   output logic [CW-1:0] CNT2
);

   rr_t           rr_ptr;
   logic [1:0]    tgt;
   logic [2:0]    free;
   logic [2:0]    load;
   logic          tgt_free;
   logic          accept;
   logic [DW-1:0] lane_data [NUM_LANES];
   logic [CW-1:0] lane_cnt  [NUM_LANES];

   assign tgt = (IN_DEST == DEST_RR) ? rr_ptr : IN_DEST;

   always_comb begin
      tgt_free = 1'b0;
      unique case (tgt)
         DEST_L0: tgt_free = free[0];
         DEST_L1: tgt_free = free[1];
         DEST_L2: tgt_free = free[2];
         default: tgt_free = 1'b0;
      endcase
   end

   // Held low during reset even though every lane reads as free.
   assign IN_READY = RSTB & tgt_free;
   assign accept   = IN_VALID & IN_READY;

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         rr_ptr <= RR_L0;
      end else if (accept && IN_DEST == DEST_RR) begin
         rr_ptr <= rr_next(rr_ptr);
      end
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      assign load[i] = accept & (tgt == 2'(i));

      lane_slot #(
         .DW(DW),
         .CW(CW)
      ) u_slot (
         .CLK      (CLK),
         .RSTB     (RSTB),
         .load     (load[i]),
         .data_in  (IN_DATA),
         .ready_in (OUT_READY[i]),
         .valid_out(OUT_VALID[i]),
         .data_out (lane_data[i]),
         .cnt      (lane_cnt[i]),
         .free     (free[i])
      );
   end

   assign OUT_DATA0 = lane_data[0];
   assign OUT_DATA1 = lane_data[1];
   assign OUT_DATA2 = lane_data[2];
   assign CNT0      = lane_cnt[0];
   assign CNT1      = lane_cnt[1];
   assign CNT2      = lane_cnt[2];

endmodule

// File: tb/tb_demux3_lane_dispatcher.sv
// Directed self-checking bench for demux3_lane_dispatcher.
// Inputs change 1 ns after the rising edge; outputs are read there.
module tb_demux3_lane_dispatcher;

   logic       CLK = 1'b0;
   logic       RSTB = 1'b0;
   logic [7:0] IN_DATA = '0;
   logic [1:0] IN_DEST = '0;
   logic       IN_VALID = 1'b0;
   logic       IN_READY;
   logic [7:0] OUT_DATA0, OUT_DATA1, OUT_DATA2;
   logic [2:0] OUT_VALID;
   logic [2:0] OUT_READY = '0;
   logic [7:0] CNT0, CNT1, CNT2;

   int n_checks = 0;
   int n_errors = 0;

   demux3_lane_dispatcher #(.DW(8), .CW(8)) dut (
      .CLK      (CLK),
      .RSTB     (RSTB),
      .IN_DATA  (IN_DATA),
      .IN_DEST  (IN_DEST),
      .IN_VALID (IN_VALID),
      .IN_READY (IN_READY),
      .OUT_DATA0(OUT_DATA0),
      .OUT_DATA1(OUT_DATA1),
      .OUT_DATA2(OUT_DATA2),
      .OUT_VALID(OUT_VALID),
      .OUT_READY(OUT_READY),
      .CNT0     (CNT0),
      .CNT1     (CNT1),
      .CNT2     (CNT2)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] d, input logic [7:0] x);
      IN_VALID = v;
      IN_DEST  = d;
      IN_DATA  = x;
      #1;
   endtask

   task automatic do_reset();
      RSTB = 1'b0;
      IN_VALID = 1'b0;
      OUT_READY = '0;
      tick();
      tick();
      RSTB = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (OUT_VALID !== 3'b000 || CNT0 !== 8'd0 || CNT1 !== 8'd0 || CNT2 !== 8'd0) begin
         n_errors++;
         $display("FAIL reset_init: valid=%b cnt=%0d/%0d/%0d want 000 0/0/0", OUT_VALID, CNT0, CNT1, CNT2);
      end
      OUT_READY = 3'b010;
      drive(1, 2'd1, 8'h01); tick();
      drive(1, 2'd1, 8'h02); tick();
      drive(1, 2'd1, 8'h03); tick();
      drive(1, 2'd1, 8'hA5); tick();
      OUT_READY = 3'b000;
      drive(0, 2'd1, 8'h00);
      n_checks++;
      if (OUT_DATA1 !== 8'hA5 || CNT1 !== 8'd4 || OUT_VALID !== 3'b010) begin
         n_errors++;
         $display("FAIL reset_preload: data1=%h cnt1=%0d valid=%b want a5 4 010", OUT_DATA1, CNT1, OUT_VALID);
      end
      #2;
      RSTB = 1'b0;
      #1;
      n_checks++;
      if (OUT_VALID !== 3'b000 || CNT1 !== 8'd0 || OUT_DATA1 !== 8'h00 || IN_READY !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_async: valid=%b cnt1=%0d data1=%h rdy=%b want 000 0 00 0", OUT_VALID, CNT1, OUT_DATA1, IN_READY);
      end
      tick();
      RSTB = 1'b1;
      drive(1, 2'd3, 8'h77);
      n_checks++;
      if (IN_READY !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_release_rdy: got %b want 1", IN_READY);
      end
      tick();
      drive(0, 2'd0, 8'h00);
      n_checks++;
      if (OUT_VALID !== 3'b001 || OUT_DATA0 !== 8'h77) begin
         n_errors++;
         $display("FAIL reset_rr_lane0: valid=%b data0=%h want 001 77", OUT_VALID, OUT_DATA0);
      end
   endtask

   task automatic test_explicit();
      do_reset();
      OUT_READY = 3'b111;
      drive(1, 2'd0, 8'h11);
      tick();
      n_checks++;
      if (OUT_VALID !== 3'b001 || OUT_DATA0 !== 8'h11) begin
         n_errors++;
         $display("FAIL explicit_l0: valid=%b data0=%h want 001 11", OUT_VALID, OUT_DATA0);
      end
      drive(1, 2'd1, 8'h22);
      tick();
      n_checks++;
      if (OUT_VALID !== 3'b010 || OUT_DATA1 !== 8'h22) begin
         n_errors++;
         $display("FAIL explicit_l1: valid=%b data1=%h want 010 22", OUT_VALID, OUT_DATA1);
      end
      drive(1, 2'd2, 8'h33);
      tick();
      n_checks++;
      if (OUT_VALID !== 3'b100 || OUT_DATA2 !== 8'h33) begin
         n_errors++;
         $display("FAIL explicit_l2: valid=%b data2=%h want 100 33", OUT_VALID, OUT_DATA2);
      end
      drive(0, 2'd0, 8'h00);
      tick();
      n_checks++;
      if (OUT_VALID !== 3'b000 || CNT0 !== 8'd1 || CNT1 !== 8'd1 || CNT2 !== 8'd1) begin
         n_errors++;
         $display("FAIL explicit_cnt: valid=%b cnt=%0d/%0d/%0d want 000 1/1/1", OUT_VALID, CNT0, CNT1, CNT2);
      end
      OUT_READY = 3'b000;
      drive(1, 2'd3, 8'h44);
      tick();
      drive(0, 2'd0, 8'h00);
      n_checks++;
      if (OUT_VALID !== 3'b001 || OUT_DATA0 !== 8'h44 || CNT0 !== 8'd2) begin
         n_errors++;
         $display("FAIL explicit_rr_unmoved: valid=%b data0=%h cnt0=%0d want 001 44 2", OUT_VALID, OUT_DATA0, CNT0);
      end
   endtask

   task automatic test_round_robin();
      logic [7:0] exp_d [3];
      exp_d[0] = 8'h01; exp_d[1] = 8'h02; exp_d[2] = 8'h03;
      do_reset();
      OUT_READY = 3'b000;
      for (int i = 0; i < 3; i++) begin
         drive(1, 2'd3, exp_d[i]);
         tick();
      end
      drive(1, 2'd3, 8'h04);
      n_checks++;
      if (OUT_VALID !== 3'b111 || OUT_DATA0 !== 8'h01 || OUT_DATA1 !== 8'h02 || OUT_DATA2 !== 8'h03) begin
         n_errors++;
         $display("FAIL rr_order: valid=%b data=%h/%h/%h want 111 01/02/03", OUT_VALID, OUT_DATA0, OUT_DATA1, OUT_DATA2);
      end
      n_checks++;
      if (IN_READY !== 1'b0) begin
         n_errors++;
         $display("FAIL rr_stall: rdy=%b want 0", IN_READY);
      end
      tick();
      n_checks++;
      if (OUT_DATA0 !== 8'h01 || CNT0 !== 8'd1) begin
         n_errors++;
         $display("FAIL rr_stall_hold: data0=%h cnt0=%0d want 01 1", OUT_DATA0, CNT0);
      end
      OUT_READY = 3'b001;
      #1;
      n_checks++;
      if (IN_READY !== 1'b1) begin
         n_errors++;
         $display("FAIL rr_drain_rdy: rdy=%b want 1", IN_READY);
      end
      tick();
      OUT_READY = 3'b000;
      drive(1, 2'd3, 8'h05);
      n_checks++;
      if (OUT_VALID !== 3'b111 || OUT_DATA0 !== 8'h04 || CNT0 !== 8'd2) begin
         n_errors++;
         $display("FAIL rr_replace: valid=%b data0=%h cnt0=%0d want 111 04 2", OUT_VALID, OUT_DATA0, CNT0);
      end
      n_checks++;
      if (IN_READY !== 1'b0) begin
         n_errors++;
         $display("FAIL rr_ptr_lane1: rdy=%b want 0", IN_READY);
      end
      drive(0, 2'd0, 8'h00);
   endtask

   task automatic test_hol_block();
      do_reset();
      OUT_READY = 3'b000;
      drive(1, 2'd2, 8'hAA);
      tick();
      drive(1, 2'd2, 8'h55);
      n_checks++;
      if (IN_READY !== 1'b0) begin
         n_errors++;
         $display("FAIL hol_rdy: rdy=%b want 0", IN_READY);
      end
      tick();
      tick();
      n_checks++;
      if (OUT_VALID !== 3'b100 || OUT_DATA2 !== 8'hAA || CNT0 !== 8'd0) begin
         n_errors++;
         $display("FAIL hol_blocked: valid=%b data2=%h cnt0=%0d want 100 aa 0", OUT_VALID, OUT_DATA2, CNT0);
      end
      OUT_READY = 3'b100;
      #1;
      tick();
      n_checks++;
      if (OUT_VALID !== 3'b100 || OUT_DATA2 !== 8'h55) begin
         n_errors++;
         $display("FAIL hol_release: valid=%b data2=%h want 100 55", OUT_VALID, OUT_DATA2);
      end
      drive(1, 2'd0, 8'h66);
      tick();
      drive(0, 2'd0, 8'h00);
      n_checks++;
      if (OUT_VALID !== 3'b001 || OUT_DATA0 !== 8'h66 || OUT_DATA2 !== 8'h55 || CNT2 !== 8'd2 || CNT0 !== 8'd1) begin
         n_errors++;
         $display("FAIL hol_next: valid=%b d0=%h d2=%h cnt2=%0d cnt0=%0d want 001 66 55 2 1", OUT_VALID, OUT_DATA0, OUT_DATA2, CNT2, CNT0);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      OUT_READY = 3'b010;
      for (int i = 0; i < 16; i++) begin
         drive(1, 2'd1, 8'(8'h80 + i));
         n_checks++;
         if (IN_READY !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_rdy[%0d]: rdy=%b want 1", i, IN_READY);
         end
         tick();
         n_checks++;
         if (OUT_VALID[1] !== 1'b1 || OUT_DATA1 !== 8'(8'h80 + i)) begin
            n_errors++;
            $display("FAIL b2b_data[%0d]: v=%b d=%h want 1 %h", i, OUT_VALID[1], OUT_DATA1, 8'(8'h80 + i));
         end
      end
      drive(0, 2'd0, 8'h00);
      n_checks++;
      if (CNT1 !== 8'd16) begin
         n_errors++;
         $display("FAIL b2b_cnt: cnt1=%0d want 16", CNT1);
      end
      tick();
      n_checks++;
      if (OUT_VALID !== 3'b000 || OUT_DATA1 !== 8'h8F) begin
         n_errors++;
         $display("FAIL b2b_drain: valid=%b d1=%h want 000 8f", OUT_VALID, OUT_DATA1);
      end
   endtask

   task automatic test_counter_wrap();
      do_reset();
      OUT_READY = 3'b001;
      for (int i = 0; i < 257; i++) begin
         drive(1, 2'd0, 8'(i));
         tick();
         if (i == 254) begin
            n_checks++;
            if (CNT0 !== 8'd255) begin
               n_errors++;
               $display("FAIL wrap_255: cnt0=%0d want 255", CNT0);
            end
         end
         if (i == 255) begin
            n_checks++;
            if (CNT0 !== 8'd0) begin
               n_errors++;
               $display("FAIL wrap_0: cnt0=%0d want 0", CNT0);
            end
         end
      end
      drive(0, 2'd0, 8'h00);
      n_checks++;
      if (CNT0 !== 8'd1 || CNT1 !== 8'd0 || CNT2 !== 8'd0) begin
         n_errors++;
         $display("FAIL wrap_1: cnt=%0d/%0d/%0d want 1/0/0", CNT0, CNT1, CNT2);
      end
   endtask

   initial begin
      test_reset();
      test_explicit();
      test_round_robin();
      test_hol_block();
      test_back_to_back();
      test_counter_wrap();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
